ntt_result_collector: RTL and testbench

//  Output-side endpoint of the NTT core stream. Tracks the core's fixed pipeline latency.

---
 rtl/ntt_result_collector_if.sv | 52 +++++
 rtl/ntt_result_collector.sv | 186 ++++++++++++++++++
 tb/tb_ntt_result_collector.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_result_collector_if.sv
// ntt_result_collector_if
//   Bundle of the collector's non-clock signals:
//     - core side: start, in_valid, cout_a, cout_b
//     - readout:   out_valid, out_ready, out_a, out_b, out_idx
//     - status:    busy, done, start_err
//   With NTT_COLLECT_CHECK_EN defined it also carries the golden-data compare
//   signals exp_a, exp_b (in) and err_cnt, first_err_idx (out).
//   The master modport is the environment (feeder, core, host).
//   The slave modport is the collector.
interface ntt_result_collector_if #(
  parameter int DATA_W = 64,
  parameter int LOG_N  = 10
);
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] cout_a;
  logic [DATA_W-1:0] cout_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [LOG_N-1:0]  out_idx;
  logic              busy;
  logic              done;
  logic              start_err;
`ifdef NTT_COLLECT_CHECK_EN
  logic [DATA_W-1:0] exp_a;
  logic [DATA_W-1:0] exp_b;
  logic [LOG_N:0]    err_cnt;
  logic [LOG_N-1:0]  first_err_idx;

  modport master (
    output start, in_valid, cout_a, cout_b, out_ready, exp_a, exp_b,
    input  out_valid, out_a, out_b, out_idx, busy, done, start_err,
           err_cnt, first_err_idx
  );
  modport slave (
    input  start, in_valid, cout_a, cout_b, out_ready, exp_a, exp_b,
    output out_valid, out_a, out_b, out_idx, busy, done, start_err,
           err_cnt, first_err_idx
  );
`else
  modport master (
    output start, in_valid, cout_a, cout_b, out_ready,
    input  out_valid, out_a, out_b, out_idx, busy, done, start_err
  );
  modport slave (
    input  start, in_valid, cout_a, cout_b, out_ready,
    output out_valid, out_a, out_b, out_idx, busy, done, start_err
  );
`endif
endinterface

// File: rtl/ntt_result_collector.sv
// ntt_result_collector
//   Output-side endpoint of the NTT core stream. The collector mirrors the
//   core's fixed latency with a LAT-deep valid delay line. It captures one
//   N-long burst of {cout_a, cout_b} into two on-chip buffers. It then streams
//   the pairs out in index order over a valid/ready port.
//   The readout runs at one word per cycle while out_ready stays high.
// Ports
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   bus      ntt_result_collector_if.slave:
//              start, in_valid, cout_a, cout_b  (in)
//              out_valid, out_a, out_b, out_idx (out), out_ready (in)
//              busy, done, start_err            (out)
// Configuration
//   NTT_COLLECT_CHECK_EN: when defined, exp_a/exp_b are compared against
//   out_a/out_b on every handshake. The result drives err_cnt (saturating at
//   N) and first_err_idx. Both clear on an accepted start.
module ntt_result_collector #(
  parameter int DATA_W = 64,
  parameter int N      = 1024,
  parameter int LOG_N  = 10,
  parameter int LAT    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  ntt_result_collector_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} state_t;

  localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);
  localparam logic [LOG_N:0]   N_CNT    = (LOG_N + 1)'(N);

  state_t            state_q, state_d;

  logic [LAT-1:0]    vld_dly;
  logic [LOG_N:0]    in_cnt;
  logic [LOG_N-1:0]  wr_idx;
  logic [LOG_N-1:0]  rd_ptr;
  logic              fetch_done;

  logic [DATA_W-1:0] mem_a [N];
  logic [DATA_W-1:0] mem_b [N];

  logic [DATA_W-1:0] rd_a_p1, rd_b_p1;
  logic [LOG_N-1:0]  rd_idx_p1;
  logic              vld_p1;

  logic              out_valid_q, done_q, start_err_q;
  logic [DATA_W-1:0] out_a_q, out_b_q;
  logic [LOG_N-1:0]  out_idx_q;

  logic start_ok, in_take, wr_en, wr_last;
  logic hs, hs_last, load, fetch;

  assign start_ok = bus.start && (state_q == IDLE);
  // Pulses beyond N per burst never enter the delay line.
  assign in_take  = (state_q == CAPTURE) && bus.in_valid && (in_cnt < N_CNT);
  assign wr_en    = (state_q == CAPTURE) && vld_dly[LAT-1];
  assign wr_last  = wr_en && (wr_idx == LAST_IDX);
  assign hs       = out_valid_q && bus.out_ready;
  assign hs_last  = hs && (out_idx_q == LAST_IDX);
  // The output register takes a new word when it is empty or being consumed.
  assign load     = (state_q == READOUT) && vld_p1 && (!out_valid_q || bus.out_ready);
  // The RAM output stage refills whenever it is empty or handing its word on.
  // This keeps the readout at 1 word/cycle despite the synchronous read.
  assign fetch    = (state_q == READOUT) && !fetch_done && (!vld_p1 || load);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = CAPTURE;
      CAPTURE: if (wr_last)  state_d = READOUT;
      READOUT: if (hs_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_dly     <= '0;
      in_cnt      <= '0;
      wr_idx      <= '0;
      rd_ptr      <= '0;
      fetch_done  <= 1'b0;
      rd_idx_p1   <= '0;
      vld_p1      <= 1'b0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      done_q <= hs_last;
      if (bus.start && (state_q != IDLE)) start_err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            // in_valid alongside start is the burst's first coefficient.
            vld_dly    <= LAT'(bus.in_valid);
            in_cnt     <= (LOG_N + 1)'(bus.in_valid);
            wr_idx     <= '0;
            rd_ptr     <= '0;
            fetch_done <= 1'b0;
            vld_p1     <= 1'b0;
          end
        end
        CAPTURE: begin
          vld_dly <= (vld_dly << 1) | LAT'(in_take);
          in_cnt  <= in_cnt + (LOG_N + 1)'(in_take);
          if (wr_en && !wr_last) wr_idx <= wr_idx + LOG_N'(1);
        end
        READOUT: begin
          // ---- stage p1: RAM read register ----
          if (fetch) begin
            rd_idx_p1 <= rd_ptr;
            if (rd_ptr == LAST_IDX) fetch_done <= 1'b1;
            else                    rd_ptr     <= rd_ptr + LOG_N'(1);
          end
          vld_p1 <= fetch || (vld_p1 && !load);
          // ---- output stage: held until handshake ----
          if (load) begin
            out_valid_q <= 1'b1;
            out_a_q     <= rd_a_p1;
            out_b_q     <= rd_b_p1;
            out_idx_q   <= rd_idx_p1;
          end else if (hs) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffers and RAM read data carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_a[wr_idx] <= bus.cout_a;
      mem_b[wr_idx] <= bus.cout_b;
    end
    if (fetch) begin
      rd_a_p1 <= mem_a[rd_ptr];
      rd_b_p1 <= mem_b[rd_ptr];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.start_err = start_err_q;

`ifdef NTT_COLLECT_CHECK_EN
  logic [LOG_N:0]   err_cnt_q;
  logic [LOG_N-1:0] first_err_q;
  logic             mism;

  assign mism = (bus.exp_a != out_a_q) || (bus.exp_b != out_b_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else if (start_ok) begin
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else if (hs && mism) begin
      if (err_cnt_q < N_CNT)      err_cnt_q   <= err_cnt_q + (LOG_N + 1)'(1);
      if (err_cnt_q == '0)        first_err_q <= out_idx_q;
    end
  end

  assign bus.err_cnt       = err_cnt_q;
  assign bus.first_err_idx = first_err_q;
`endif

endmodule

// File: tb/tb_ntt_result_collector.sv
module tb_ntt_result_collector;
  localparam int DATA_W = 64;
  localparam int N      = 8;
  localparam int LOG_N  = 3;
  localparam int LAT    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ntt_result_collector_if #(.DATA_W(DATA_W), .LOG_N(LOG_N)) ifc ();

  ntt_result_collector #(.DATA_W(DATA_W), .N(N), .LOG_N(LOG_N), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  // Core model: a coefficient fed in cycle t shows its result on cout_* in cycle t+LAT.
  bit pv [LAT];
  int pk [LAT];
  int feed_k    = 0;
  int core_base = 0;
  int cyc       = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] <= pv[i-1];
      pk[i] <= pk[i-1];
    end
    pv[0] <= ifc.in_valid;
    pk[0] <= feed_k;
  end

  assign ifc.cout_a = pv[LAT-1] ? 64'(core_base + pk[LAT-1] + 1)   : 64'hDEAD_BEEF_0000_0000;
  assign ifc.cout_b = pv[LAT-1] ? 64'(core_base + 100 + pk[LAT-1]) : 64'hDEAD_BEEF_0000_0000;

`ifdef NTT_COLLECT_CHECK_EN
  int bad_a_idx = -1;
  int bad_b_idx = -1;
  assign ifc.exp_a = 64'(core_base + int'(ifc.out_idx) + 1)
                   ^ ((int'(ifc.out_idx) == bad_a_idx) ? 64'h10 : 64'h0);
  assign ifc.exp_b = 64'(core_base + 100 + int'(ifc.out_idx))
                   ^ ((int'(ifc.out_idx) == bad_b_idx) ? 64'h20 : 64'h0);
`endif

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feeds pat[0..len-1] as in_valid, with start in cycle 0 and again in
  // cycle extra_start (-1 for none). t_last is the cycle of the N-th in_valid.
  task automatic run_capture(input logic [31:0] pat, input int len, input int base,
                             input int extra_start, output int t_last);
    int fed;
    fed       = 0;
    t_last    = -1;
    core_base = base;
    for (int i = 0; i < len; i++) begin
      ifc.start    = (i == 0) || (i == extra_start);
      ifc.in_valid = pat[i];
      feed_k       = fed;
      if (pat[i]) begin
        if (fed == N - 1) t_last = cyc;
        fed++;
      end
      step();
    end
    ifc.start    = 1'b0;
    ifc.in_valid = 1'b0;
  endtask

  // Collects N words; first_exp >= 0 also checks the cycle of the first out_valid.
  task automatic readout(input string tname, input int base, input bit rnd, input int first_exp);
    int          got, k;
    bit          stalled, seen;
    logic        rdy;
    logic [63:0] pa, pb, pi;
    got = 0; k = 0; stalled = 0; seen = 0; pa = 0; pb = 0; pi = 0;
    while (got < N && k < 400) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ifc.out_ready = rdy;
      if (stalled) begin
        check({tname, "_stall_vld"}, ifc.out_valid, 1);
        check({tname, "_stall_idx"}, ifc.out_idx, pi);
        check({tname, "_stall_a"}, ifc.out_a, pa);
        check({tname, "_stall_b"}, ifc.out_b, pb);
        stalled = 0;
      end
      if (ifc.out_valid) begin
        if (!seen && first_exp >= 0) check({tname, "_first_vld_cycle"}, cyc, first_exp);
        seen = 1;
        check({tname, "_busy"}, ifc.busy, 1);
        if (rdy) begin
          check({tname, "_idx"}, ifc.out_idx, got);
          check({tname, "_a"}, ifc.out_a, 64'(base + got + 1));
          check({tname, "_b"}, ifc.out_b, 64'(base + 100 + got));
          got++;
        end else begin
          stalled = 1;
          pa = ifc.out_a; pb = ifc.out_b; pi = 64'(ifc.out_idx);
        end
      end
      check({tname, "_no_early_done"}, ifc.done, 0);
      step();
      k++;
    end
    check({tname, "_word_count"}, got, N);
    ifc.out_ready = 1'b0;
    check({tname, "_done"}, ifc.done, 1);
    check({tname, "_busy_drop"}, ifc.busy, 0);
    check({tname, "_vld_drop"}, ifc.out_valid, 0);
    step();
    check({tname, "_done_1cyc"}, ifc.done, 0);
  endtask

  int t_last;
  int k;

  initial begin
    ifc.start     = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_done", ifc.done, 0);
    check("rst_start_err", ifc.start_err, 0);
    check("rst_out_a", ifc.out_a, 0);
    check("rst_out_b", ifc.out_b, 0);
    check("rst_out_idx", ifc.out_idx, 0);
    reset = 1'b1;
    step();

    // in_valid without start is ignored in IDLE
    ifc.in_valid = 1'b1;
    step(); step(); step();
    ifc.in_valid = 1'b0;
    check("idle_busy", ifc.busy, 0);
    check("idle_vld", ifc.out_valid, 0);

    // T1: contiguous burst plus two surplus pulses that must be dropped
    run_capture(32'h3FF, 10, 0, -1, t_last);
    readout("t1", 0, 1'b0, -1);
`ifdef NTT_COLLECT_CHECK_EN
    check("t1_err_cnt", ifc.err_cnt, 0);
`endif

    // T2: gapped feed; first out_valid = (N-th in_valid) + LAT + 1 (READOUT entry) + 2
    run_capture(32'h1AD9, 13, 200, -1, t_last);
    readout("t2", 200, 1'b0, t_last + LAT + 3);

    // T3: random backpressure
    run_capture(32'hFF, 8, 300, -1, t_last);
    readout("t3", 300, 1'b1, -1);
    check("t3_start_err", ifc.start_err, 0);

    // T4: start while capturing word 3
    run_capture(32'hFF, 8, 0, 3, t_last);
    check("t4_start_err", ifc.start_err, 1);
    readout("t4", 0, 1'b0, -1);
    check("t4_start_err_sticky", ifc.start_err, 1);

    // T5: reset during readout at idx 5
    run_capture(32'hFF, 8, 500, -1, t_last);
    ifc.out_ready = 1'b1;
    k = 0;
    while (!(ifc.out_valid && ifc.out_idx == 3'd5) && k < 100) begin
      step();
      k++;
    end
    check("t5_reach_idx5", (k < 100), 1);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_vld", ifc.out_valid, 0);
    check("t5_rst_busy", ifc.busy, 0);
    check("t5_rst_idx", ifc.out_idx, 0);
    check("t5_rst_a", ifc.out_a, 0);
    check("t5_rst_start_err", ifc.start_err, 0);
    ifc.out_ready = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    run_capture(32'hFF, 8, 1000, -1, t_last);
    readout("t5", 1000, 1'b0, -1);

`ifdef NTT_COLLECT_CHECK_EN
    // T6: golden data wrong at idx 2 lane b and idx 6 lane a
    bad_b_idx = 2;
    bad_a_idx = 6;
    run_capture(32'hFF, 8, 2000, -1, t_last);
    ifc.out_ready = 1'b1;
    k = 0;
    while (!ifc.done && k < 100) begin
      step();
      k++;
    end
    ifc.out_ready = 1'b0;
    check("t6_done_seen", ifc.done, 1);
    check("t6_err_cnt", ifc.err_cnt, 2);
    check("t6_first_err_idx", ifc.first_err_idx, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
